// File: rtl/bus_rr_interconnect.sv
// bus_rr_interconnect: round-robin arbitration of NrHosts single-outstanding hosts onto NrDevices devices,
// with decode-miss error responses; defining BUS_TIMEOUT_EN adds a device response timeout.
module bus_rr_interconnect #(
    parameter int NrHosts       = 3,
    parameter int NrDevices     = 7,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,
    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);
    localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
    localparam int DW = NrDevices > 1 ? $clog2(NrDevices) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
    state_t state, state_next;
    logic [HW-1:0] last_grant, host_sel, gnt_idx, cand;
    logic [DW-1:0] dev_sel, dev_idx;
    logic gnt_any, hit, dev_rv, timeout, resp;

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_grant;
        cand    = '0;
        for (int i = NrHosts; i >= 1; i--) begin
            cand = HW'((int'(last_grant) + i) % NrHosts);
            if (host_req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_any = gnt_any && state == IDLE && !rst_i;
    end

    always_comb begin
        hit     = 1'b0;
        dev_idx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((host_addr_i[gnt_idx] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                hit     = 1'b1;
                dev_idx = DW'(d);
            end
        end
    end

    assign dev_rv = state == WAIT && device_rvalid_i[dev_sel];
    assign resp   = state == ERR || dev_rv || timeout;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= '0;
        else       cnt <= state == WAIT ? cnt + 1'b1 : '0;
    end

    assign timeout = state == WAIT && cnt == CW'(TimeoutCycles);
`else
    // Timeout never fires; TimeoutCycles is only referenced so the parameter list stays uniform.
    assign timeout = TimeoutCycles < 0;
`endif

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        device_req_o  = '0;
        device_we_o   = '0;
        for (int h = 0; h < NrHosts; h++) host_rdata_o[h] = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = '0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
        end
        if (gnt_any) begin
            host_gnt_o[gnt_idx] = 1'b1;
            if (hit) begin
                device_req_o[dev_idx]   = 1'b1;
                device_addr_o[dev_idx]  = host_addr_i[gnt_idx];
                device_we_o[dev_idx]    = host_we_i[gnt_idx];
                device_be_o[dev_idx]    = host_be_i[gnt_idx];
                device_wdata_o[dev_idx] = host_wdata_i[gnt_idx];
            end
        end
        if (resp) begin
            host_rvalid_o[host_sel] = 1'b1;
            host_err_o[host_sel]    = state == ERR || (dev_rv ? device_err_i[dev_sel] : timeout);
            host_rdata_o[host_sel]  = dev_rv ? device_rdata_i[dev_sel] : '0;
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && gnt_any) state_next = hit ? WAIT : ERR;
        else if (resp)                state_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= HW'(NrHosts - 1);
            host_sel   <= '0;
            dev_sel    <= '0;
        end else begin
            state <= state_next;
            if (gnt_any) begin
                last_grant <= gnt_idx;
                host_sel   <= gnt_idx;
                dev_sel    <= dev_idx;
            end
        end
    end
endmodule
